// File: rtl/piezo_scheduler.sv
// rtl/piezo_scheduler.sv - single-pin tone arbiter for alarm, chime and keypad click
// Optional snooze behaviour on mute is enabled by defining PIEZO_SNOOZE_EN.
module piezo_scheduler #(
  parameter int CNT_W         = 32,
  parameter int KEY_HALF      = 25000,
  parameter int KEY_LEN       = 5000000,
  parameter int CHIME_HALF    = 50000,
  parameter int CHIME_LEN     = 25000000,
  parameter int ALARM_HALF    = 12500,
  parameter int ALARM_ON_LEN  = 12500000,
  parameter int ALARM_OFF_LEN = 12500000,
  parameter int SNOOZE_LEN    = 250000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_pulse,
  input  logic       chime_pulse,
  input  logic       alarm_req,
  input  logic       mute,
  output logic       piezo,
  output logic [2:0] grant,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KEY    = 3'd1;
  localparam logic [2:0] S_CHIME  = 3'd2;
  localparam logic [2:0] S_ON     = 3'd3;
  localparam logic [2:0] S_OFF    = 3'd4;
  localparam logic [2:0] S_SNOOZE = 3'd5;

  logic [2:0]       state, next_state;
  logic [CNT_W-1:0] dur_cnt, half_cnt, dur_last, half_last;
  logic             key_pend, chime_pend, alarm_eff;
  logic             dur_done, half_done, enter, retrig, tone_state;

`ifdef PIEZO_SNOOZE_EN
  assign alarm_eff = alarm_req;
`else
  logic mute_lat;

  // mute silences immediately; the latch keeps it silent until alarm_req drops
  assign alarm_eff = alarm_req & ~mute_lat & ~mute;

  always_ff @(posedge clk) begin
    if (resetn)          mute_lat <= 1'b0;
    else if (!alarm_req) mute_lat <= 1'b0;
    else if (mute)       mute_lat <= 1'b1;
  end
`endif

  always_comb begin
    dur_last  = '0;
    half_last = '0;
    case (state)
      S_KEY:    begin dur_last = CNT_W'(KEY_LEN - 1);   half_last = CNT_W'(KEY_HALF - 1);   end
      S_CHIME:  begin dur_last = CNT_W'(CHIME_LEN - 1); half_last = CNT_W'(CHIME_HALF - 1); end
      S_ON:     begin dur_last = CNT_W'(ALARM_ON_LEN - 1); half_last = CNT_W'(ALARM_HALF - 1); end
      S_OFF:    dur_last = CNT_W'(ALARM_OFF_LEN - 1);
      S_SNOOZE: dur_last = CNT_W'(SNOOZE_LEN - 1);
      default:  dur_last = '0;
    endcase
  end

  assign dur_done   = (dur_cnt == dur_last);
  assign half_done  = (half_cnt == half_last);
  assign tone_state = (state == S_KEY) || (state == S_CHIME) || (state == S_ON);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (alarm_eff)                       next_state = S_ON;
        else if (chime_pend || chime_pulse)  next_state = S_CHIME;
        else if (key_pend || key_pulse)      next_state = S_KEY;
      end
      S_KEY: begin
        if (alarm_eff)                       next_state = S_ON;
        else if (!key_pulse && dur_done)     next_state = S_IDLE;
      end
      S_CHIME: begin
        if (alarm_eff)                       next_state = S_ON;
        else if (!chime_pulse && dur_done)   next_state = S_IDLE;
      end
      S_ON: begin
        if (!alarm_eff)                      next_state = S_IDLE;
`ifdef PIEZO_SNOOZE_EN
        else if (mute)                       next_state = S_SNOOZE;
`endif
        else if (dur_done)                   next_state = S_OFF;
      end
      S_OFF: begin
        if (!alarm_eff)                      next_state = S_IDLE;
`ifdef PIEZO_SNOOZE_EN
        else if (mute)                       next_state = S_SNOOZE;
`endif
        else if (dur_done)                   next_state = S_ON;
      end
      S_SNOOZE: begin
        if (!alarm_req)                      next_state = S_IDLE;
        else if (dur_done)                   next_state = S_ON;
      end
      default:                               next_state = S_IDLE;
    endcase
  end

  assign enter  = (next_state != state);
  assign retrig = ((state == S_KEY) && key_pulse && (next_state == S_KEY)) ||
                  ((state == S_CHIME) && chime_pulse && (next_state == S_CHIME));

  always_ff @(posedge clk) begin
    if (resetn) begin
      state    <= S_IDLE;
      dur_cnt  <= '0;
      half_cnt <= '0;
      piezo    <= 1'b0;
      grant    <= 3'b000;
      busy     <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != S_IDLE);
      case (next_state)
        S_ON:    grant <= 3'b100;
        S_CHIME: grant <= 3'b010;
        S_KEY:   grant <= 3'b001;
        default: grant <= 3'b000;
      endcase

      if (enter || retrig || (state == S_IDLE)) dur_cnt <= '0;
      else                                      dur_cnt <= dur_cnt + 1'b1;

      if (enter || !tone_state) begin
        half_cnt <= '0;
        piezo    <= 1'b0;
      end else if (half_done) begin
        half_cnt <= '0;
        piezo    <= ~piezo;
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
    end
  end

  // Alarm preemption drops the click but re-queues an interrupted chime
  always_ff @(posedge clk) begin
    if (resetn) begin
      key_pend   <= 1'b0;
      chime_pend <= 1'b0;
    end else begin
      if ((next_state == S_KEY) || (next_state == S_ON) || (state == S_ON) || (state == S_OFF))
        key_pend <= 1'b0;
      else if (key_pulse && (state != S_KEY))
        key_pend <= 1'b1;

      if (enter && (next_state == S_CHIME))
        chime_pend <= 1'b0;
      else if (((state == S_CHIME) && (next_state == S_ON)) || (chime_pulse && (state != S_CHIME)))
        chime_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_piezo_scheduler.sv
// tb/tb_piezo_scheduler.sv - directed vector bench for piezo_scheduler
module tb_piezo_scheduler;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       key_pulse = 1'b0;
  logic       chime_pulse = 1'b0;
  logic       alarm_req = 1'b0;
  logic       mute = 1'b0;
  logic       piezo;
  logic [2:0] grant;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int n;

  typedef struct {
    logic       k, c, a, m;
    logic [2:0] g;
    logic       b, p;
    int         tag;
  } vec_t;

  vec_t vecs[$];

  piezo_scheduler #(
    .CNT_W(32), .KEY_HALF(2), .KEY_LEN(20), .CHIME_HALF(3), .CHIME_LEN(30),
    .ALARM_HALF(1), .ALARM_ON_LEN(8), .ALARM_OFF_LEN(8), .SNOOZE_LEN(40)
  ) dut (
    .clk(clk), .resetn(resetn), .key_pulse(key_pulse), .chime_pulse(chime_pulse),
    .alarm_req(alarm_req), .mute(mute), .piezo(piezo), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input logic k, input logic c, input logic a, input logic m,
                      input logic [2:0] g, input logic b, input logic p, input int tag);
    vec_t v;
    v.k = k; v.c = c; v.a = a; v.m = m; v.g = g; v.b = b; v.p = p; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual{grant,busy,piezo}=%b required=%b", nm, act, exp);
    end
  endtask

  function automatic logic bitof(input int v);
    return (v % 2) == 1;
  endfunction

  initial begin
    // key click from idle
    addv(1, 0, 0, 0, 3'b001, 1, 0, 1);
    for (int k = 1; k < 20; k++) addv(0, 0, 0, 0, 3'b001, 1, bitof(k / 2), 1);
    addv(0, 0, 0, 0, 3'b000, 0, 0, 1);
    addv(0, 0, 0, 0, 3'b000, 0, 0, 1);
    // key and chime together: chime first, one idle cycle, then key
    addv(1, 1, 0, 0, 3'b010, 1, 0, 2);
    for (int k = 1; k < 30; k++) addv(0, 0, 0, 0, 3'b010, 1, bitof(k / 3), 2);
    addv(0, 0, 0, 0, 3'b000, 0, 0, 2);
    for (int k = 0; k < 20; k++) addv(0, 0, 0, 0, 3'b001, 1, bitof(k / 2), 2);
    addv(0, 0, 0, 0, 3'b000, 0, 0, 2);
    // chime preempted by alarm at chime cycle 12, then requeued at full length
    addv(0, 1, 0, 0, 3'b010, 1, 0, 3);
    for (int k = 1; k <= 12; k++) addv(0, 0, 0, 0, 3'b010, 1, bitof(k / 3), 3);
    for (int j = 0; j <= 20; j++) begin
      if ((j % 16) < 8) addv(0, 0, 1, 0, 3'b100, 1, bitof(j), 3);
      else              addv(0, 0, 1, 0, 3'b000, 1, 0, 3);
    end
    addv(0, 0, 0, 0, 3'b000, 0, 0, 3);
    for (int k = 0; k < 30; k++) addv(0, 0, 0, 0, 3'b010, 1, bitof(k / 3), 3);
    addv(0, 0, 0, 0, 3'b000, 0, 0, 3);
`ifndef PIEZO_SNOOZE_EN
    // mute silences until alarm_req falls, then the alarm can ring again
    for (int j = 0; j < 4; j++) addv(0, 0, 1, 0, 3'b100, 1, bitof(j), 4);
    addv(0, 0, 1, 1, 3'b000, 0, 0, 4);
    for (int j = 0; j < 6; j++) addv(0, 0, 1, 0, 3'b000, 0, 0, 4);
    addv(0, 0, 0, 0, 3'b000, 0, 0, 4);
    addv(0, 0, 1, 0, 3'b100, 1, 0, 4);
    addv(0, 0, 1, 0, 3'b100, 1, 1, 4);
    addv(0, 0, 0, 0, 3'b000, 0, 0, 4);
`endif

    resetn = 1'b1;
    repeat (3) tick();
    chk("reset_state", {grant, busy, piezo}, 5'b00000);
    resetn = 1'b0;
    tick();
    chk("post_reset_idle", {grant, busy, piezo}, 5'b00000);

    for (int i = 0; i < vecs.size(); i++) begin
      key_pulse = vecs[i].k; chime_pulse = vecs[i].c; alarm_req = vecs[i].a; mute = vecs[i].m;
      tick();
      chk($sformatf("vec[%0d] scen=%0d", i, vecs[i].tag), {grant, busy, piezo},
          {vecs[i].g, vecs[i].b, vecs[i].p});
    end
    key_pulse = 0; chime_pulse = 0; alarm_req = 0; mute = 0;
    tick();

    // key retriggered every 5 cycles keeps KEY alive past its nominal length
    key_pulse = 1; tick(); key_pulse = 0;
    for (int r = 0; r < 5; r++) begin
      repeat (4) tick();
      key_pulse = 1; tick(); key_pulse = 0;
      chk($sformatf("retrig_hold%0d", r), {grant, busy}, 4'b0011);
    end
    n = 0;
    while (grant == 3'b001 && n < 100) begin tick(); n++; end
    chk("retrig_tail_len", 5'(n), 5'd20);

    // chime waits for an active key click
    tick();
    key_pulse = 1; tick(); key_pulse = 0;
    chime_pulse = 1; tick(); chime_pulse = 0;
    chk("chime_no_preempt", {grant, busy}, 4'b0011);
    repeat (18) tick();
    chk("key_last_cycle", {grant, busy}, 4'b0011);
    tick();
    chk("gap_before_chime", {grant, busy, piezo}, 5'b00000);
    tick();
    chk("pending_chime_start", {grant, busy, piezo}, 5'b01010);
    repeat (29) tick();
    chk("chime_last_cycle", {grant, busy}, 4'b0101);
    tick();
    chk("chime_done", {grant, busy, piezo}, 5'b00000);

    // reset mid-operation clears state and pending requests
    key_pulse = 1; tick(); key_pulse = 0;
    chime_pulse = 1; tick(); chime_pulse = 0;
    repeat (3) tick();
    resetn = 1'b1; tick();
    chk("mid_reset", {grant, busy, piezo}, 5'b00000);
    resetn = 1'b0; tick();
    chk("pend_cleared_a", {grant, busy, piezo}, 5'b00000);
    tick();
    chk("pend_cleared_b", {grant, busy, piezo}, 5'b00000);

`ifdef PIEZO_SNOOZE_EN
    alarm_req = 1; repeat (3) tick();
    chk("snz_alarm_on", {grant, busy, piezo}, 5'b10010);
    mute = 1; tick(); mute = 0;
    chk("snz_enter", {grant, busy, piezo}, 5'b00010);
    repeat (39) tick();
    chk("snz_last", {grant, busy, piezo}, 5'b00010);
    tick();
    chk("snz_resume", {grant, busy, piezo}, 5'b10010);
    mute = 1; tick(); mute = 0;
    chk("snz_again", {grant, busy, piezo}, 5'b00010);
    tick();
    alarm_req = 0; tick();
    chk("snz_drop", {grant, busy, piezo}, 5'b00000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
